// File: rtl/mod6_seq_checker_pkg.sv
// Shared types and constants for the mod-6 sequence checkers.
package mod6_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } chk_state_e;

  localparam logic [2:0] MOD6_LAST        = 3'd5;
  localparam logic [2:0] MOD6_ILLEGAL_MIN = 3'd6;

endpackage

// File: rtl/mod6_seq_checker_if.sv
// Bundles the checker's sampled inputs and its status outputs.
interface mod6_seq_checker_if #(
  parameter int WRAP_W = 8
);
  logic [2:0]        count_in;
  logic              chk_en;
  logic              clr_err;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              err_illegal;
  logic              err_skip;
  logic [2:0]        err_first;
  logic [1:0]        state;

  modport master (
    output count_in, chk_en, clr_err,
    input  wrap_pulse, wrap_cnt, err_illegal, err_skip, err_first, state
  );

  modport slave (
    input  count_in, chk_en, clr_err,
    output wrap_pulse, wrap_cnt, err_illegal, err_skip, err_first, state
  );
endinterface

// File: rtl/mod6_seq_checker_next.sv
// Combinational mod-6 successor (5 wraps to 0) with an illegal-code detect.
module mod6_next
  import mod6_chk_pkg::*;
(
  input  logic [2:0] i_value,
  output logic [2:0] o_next,
  output logic       o_illegal
);

  always_comb begin
    o_illegal = (i_value >= MOD6_ILLEGAL_MIN);
    o_next    = (i_value == MOD6_LAST) ? 3'd0 : i_value + 3'd1;
  end

endmodule

// File: rtl/mod6_seq_checker.sv
// Checks a mod-6 counter stream: sticky error flags, first-error capture,
// and a wrap pulse with a saturating wrap count for the next cascaded stage.
module mod6_seq_checker
  import mod6_chk_pkg::*;
#(
  parameter int WRAP_W = 8
) (
  input logic               clk,
  input logic               rst,
  mod6_seq_checker_if.slave bus
);

  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  chk_state_e        r_state;
  chk_state_e        w_stateNext;
  logic [2:0]        r_prev;
  logic [2:0]        r_expect;
  logic [2:0]        r_errFirst;
  logic              r_errIllegal;
  logic              r_errSkip;
  logic              r_wrapPulse;
  logic [WRAP_W-1:0] r_wrapCnt;

  logic [2:0]        w_prevNext;
  logic [2:0]        w_expectNext;
  logic [2:0]        w_errFirstNext;
  logic [2:0]        w_inSucc;
  logic              w_inIllegal;
  logic              w_errIllegalNext;
  logic              w_errSkipNext;
  logic              w_wrapPulseNext;
  logic              w_flagsClean;
  logic              w_raiseIllegal;
  logic              w_raiseSkip;
  logic [WRAP_W-1:0] w_wrapCntNext;

  // Successor of the incoming sample is registered alongside prev so the
  // next cycle's sequence check is a plain compare against r_expect.
  mod6_next u_next (
    .i_value   (bus.count_in),
    .o_next    (w_inSucc),
    .o_illegal (w_inIllegal)
  );

  always_comb begin
    w_stateNext      = r_state;
    w_prevNext       = r_prev;
    w_expectNext     = r_expect;
    w_errIllegalNext = r_errIllegal;
    w_errSkipNext    = r_errSkip;
    w_errFirstNext   = r_errFirst;
    w_wrapCntNext    = r_wrapCnt;
    w_wrapPulseNext  = 1'b0;
    w_raiseIllegal   = 1'b0;
    w_raiseSkip      = 1'b0;
    w_flagsClean     = !r_errIllegal && !r_errSkip;

    if (bus.clr_err) begin
      w_errIllegalNext = 1'b0;
      w_errSkipNext    = 1'b0;
      w_errFirstNext   = 3'd0;
      w_wrapCntNext    = '0;
    end

    if (!bus.chk_en) begin
      w_stateNext = IDLE;
    end else begin
      unique case (r_state)
        IDLE: w_stateNext = SYNC;
        SYNC: begin
          w_prevNext   = bus.count_in;
          w_expectNext = w_inSucc;
          if (w_inIllegal) w_raiseIllegal = 1'b1;
          else             w_stateNext    = TRACK;
        end
        TRACK: begin
          if (w_inIllegal) begin
            w_raiseIllegal = 1'b1;
          end else if (bus.count_in != r_expect) begin
            w_raiseSkip = 1'b1;
          end else begin
            w_prevNext   = bus.count_in;
            w_expectNext = w_inSucc;
            if (r_prev == MOD6_LAST) begin
              w_wrapPulseNext = 1'b1;
              w_wrapCntNext   = (w_wrapCntNext == WRAP_MAX) ? WRAP_MAX
                                                            : w_wrapCntNext + WRAP_ONE;
            end
          end
        end
        // Leaving FAULT still screens the sample: an illegal code seen with
        // the clear re-arms the flag and keeps the checker parked here.
        FAULT: begin
          if (bus.clr_err) begin
            if (w_inIllegal) w_raiseIllegal = 1'b1;
            else             w_stateNext    = SYNC;
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end

    if (w_raiseIllegal || w_raiseSkip) begin
      w_stateNext = FAULT;
      if (w_flagsClean || bus.clr_err) w_errFirstNext = bus.count_in;
      if (w_raiseIllegal) w_errIllegalNext = 1'b1;
      if (w_raiseSkip)    w_errSkipNext    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prev       <= 3'd0;
      r_expect     <= 3'd1;
      r_errIllegal <= 1'b0;
      r_errSkip    <= 1'b0;
      r_errFirst   <= 3'd0;
      r_wrapPulse  <= 1'b0;
      r_wrapCnt    <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_prev       <= w_prevNext;
      r_expect     <= w_expectNext;
      r_errIllegal <= w_errIllegalNext;
      r_errSkip    <= w_errSkipNext;
      r_errFirst   <= w_errFirstNext;
      r_wrapPulse  <= w_wrapPulseNext;
      r_wrapCnt    <= w_wrapCntNext;
    end
  end

  assign bus.wrap_pulse  = r_wrapPulse;
  assign bus.wrap_cnt    = r_wrapCnt;
  assign bus.err_illegal = r_errIllegal;
  assign bus.err_skip    = r_errSkip;
  assign bus.err_first   = r_errFirst;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_mod6_seq_checker.sv
// Self-checking bench: two checkers (WRAP_W=8 and WRAP_W=2) share one stimulus
// stream and are compared every cycle against a rule-level model.
module tb_mod6_seq_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   checkOn = 1'b0;

  int errCount   = 0;
  int checkCount = 0;

  int mPhase = 0;
  int mPrev  = 0;
  int mFirst = 0;
  int mWraps = 0;
  bit mIll   = 1'b0;
  bit mSkip  = 1'b0;
  bit mPulse = 1'b0;

  int satSeq [5] = '{1, 2, 3, 3, 3};

  always #5 clk = ~clk;

  mod6_seq_checker_if #(.WRAP_W(8)) bus8 ();
  mod6_seq_checker_if #(.WRAP_W(2)) bus2 ();

  mod6_seq_checker #(.WRAP_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  mod6_seq_checker #(.WRAP_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int satCnt(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic modelRaise(input bit isIllegal, input int v, input bit loadFirst);
    if (loadFirst) mFirst = v;
    if (isIllegal) mIll = 1'b1;
    else           mSkip = 1'b1;
    mPhase = 3;
  endtask

  // Rule-level reference: phases are the debug state codes, prev holds the last accepted value.
  task automatic modelStep(input bit en, input bit clr, input int v);
    bit clean;
    bit ill;
    clean  = !mIll && !mSkip;
    ill    = (v >= 6);
    mPulse = 1'b0;
    if (clr) begin
      mIll = 1'b0; mSkip = 1'b0; mFirst = 0; mWraps = 0;
    end
    if (!en) begin
      mPhase = 0;
    end else begin
      case (mPhase)
        0: mPhase = 1;
        1: begin
          mPrev = v;
          if (ill) modelRaise(1'b1, v, clean || clr);
          else     mPhase = 2;
        end
        2: begin
          if (ill)                          modelRaise(1'b1, v, clean || clr);
          else if (v != (mPrev + 1) % 6)    modelRaise(1'b0, v, clean || clr);
          else begin
            if (v == 0) begin
              mPulse = 1'b1;
              mWraps++;
            end
            mPrev = v;
          end
        end
        3: begin
          if (clr) begin
            if (ill) modelRaise(1'b1, v, 1'b1);
            else     mPhase = 1;
          end
        end
        default: mPhase = 0;
      endcase
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase = 0; mPrev = 0; mFirst = 0; mWraps = 0;
      mIll = 1'b0; mSkip = 1'b0; mPulse = 1'b0;
    end else begin
      modelStep(bus8.chk_en, bus8.clr_err, int'(bus8.count_in));
    end
  end

  always @(negedge clk) begin
    if (checkOn && !rst) begin
      checkOutput("state8",       bus8.state,       mPhase);
      checkOutput("pulse8",       bus8.wrap_pulse,  mPulse);
      checkOutput("wrapcnt8",     bus8.wrap_cnt,    satCnt(mWraps, 255));
      checkOutput("illegal8",     bus8.err_illegal, mIll);
      checkOutput("skip8",        bus8.err_skip,    mSkip);
      checkOutput("first8",       bus8.err_first,   mFirst);
      checkOutput("state2",       bus2.state,       mPhase);
      checkOutput("pulse2",       bus2.wrap_pulse,  mPulse);
      checkOutput("wrapcnt2",     bus2.wrap_cnt,    satCnt(mWraps, 3));
      checkOutput("illegal2",     bus2.err_illegal, mIll);
    end
  end

  task automatic applyStimulus(input bit en, input bit clr, input logic [2:0] val);
    @(negedge clk);
    bus8.chk_en = en; bus8.clr_err = clr; bus8.count_in = val;
    bus2.chk_en = en; bus2.clr_err = clr; bus2.count_in = val;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_state"},   bus8.state,       0);
    checkOutput({tag, "_pulse"},   bus8.wrap_pulse,  0);
    checkOutput({tag, "_wrapcnt"}, bus8.wrap_cnt,    0);
    checkOutput({tag, "_illegal"}, bus8.err_illegal, 0);
    checkOutput({tag, "_skip"},    bus8.err_skip,    0);
    checkOutput({tag, "_first"},   bus8.err_first,   0);
    checkOutput({tag, "_state2"},  bus2.state,       0);
    checkOutput({tag, "_wrap2"},   bus2.wrap_cnt,    0);
  endtask

  initial begin
    int pulses;
    int lastPulse;
    int cnt;
    bit en;
    bit clr;
    logic [2:0] v;

    bus8.chk_en = 1'b0; bus8.clr_err = 1'b0; bus8.count_in = 3'd0;
    bus2.chk_en = 1'b0; bus2.clr_err = 1'b0; bus2.count_in = 3'd0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;
    checkOn = 1'b1;

    pulses = 0;
    lastPulse = -1;
    for (int i = 0; i < 31; i++) begin
      applyStimulus(1'b1, 1'b0, 3'(i % 6));
      if (bus8.wrap_pulse === 1'b1) begin
        pulses++;
        if (lastPulse >= 0) checkOutput("pulse_gap", i - lastPulse, 6);
        lastPulse = i;
        if (pulses <= 5) checkOutput("sat_wrap2", bus2.wrap_cnt, satSeq[pulses-1]);
      end
    end
    checkOutput("run_pulses",  pulses, 5);
    checkOutput("run_wrapcnt", bus8.wrap_cnt, 5);
    checkOutput("run_state",   bus8.state, 2);
    checkOutput("run_flags",   {bus8.err_illegal, bus8.err_skip}, 0);

    applyStimulus(1'b1, 1'b0, 3'd7);
    checkOutput("inj7_illegal", bus8.err_illegal, 1);
    checkOutput("inj7_first",   bus8.err_first, 7);
    checkOutput("inj7_state",   bus8.state, 3);
    pulses = 0;
    for (int i = 32; i < 44; i++) begin
      applyStimulus(1'b1, 1'b0, 3'(i % 6));
      if (bus8.wrap_pulse === 1'b1) pulses++;
    end
    checkOutput("fault_no_pulse", pulses, 0);

    applyStimulus(1'b1, 1'b1, 3'd0);
    checkOutput("clr_state",   bus8.state, 1);
    checkOutput("clr_wrapcnt", bus8.wrap_cnt, 0);
    applyStimulus(1'b1, 1'b0, 3'd1);
    applyStimulus(1'b1, 1'b0, 3'd2);
    applyStimulus(1'b1, 1'b0, 3'd4);
    checkOutput("skip_flag",  bus8.err_skip, 1);
    checkOutput("skip_first", bus8.err_first, 4);
    checkOutput("skip_state", bus8.state, 3);
    applyStimulus(1'b1, 1'b1, 3'd6);
    checkOutput("errwin_illegal", bus8.err_illegal, 1);
    checkOutput("errwin_skip",    bus8.err_skip, 0);
    checkOutput("errwin_first",   bus8.err_first, 6);
    checkOutput("errwin_state",   bus8.state, 3);

    applyStimulus(1'b1, 1'b1, 3'd0);
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b0, 3'((1 + k) % 6));
    checkOutput("resync_wrapcnt", bus8.wrap_cnt, 3);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 3'(3 + k));
    checkOutput("dis_state",   bus8.state, 0);
    checkOutput("dis_wrapcnt", bus8.wrap_cnt, 3);
    applyStimulus(1'b1, 1'b0, 3'd3);
    checkOutput("en_sync", bus8.state, 1);
    applyStimulus(1'b1, 1'b0, 3'd3);
    checkOutput("en_track", bus8.state, 2);
    applyStimulus(1'b1, 1'b0, 3'd4);
    checkOutput("en_accept_state", bus8.state, 2);
    checkOutput("en_accept_flags", {bus8.err_illegal, bus8.err_skip}, 0);
    checkOutput("en_wrapcnt",      bus8.wrap_cnt, 3);

    applyStimulus(1'b1, 1'b0, 3'd7);
    checkOutput("pre_rst_state", bus8.state, 3);
    #3;
    rst = 1'b1;
    #1;
    checkAllZero("async_rst");
    @(negedge clk);
    rst = 1'b0;

    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      en  = ($urandom_range(0, 99) < 95);
      clr = en && ($urandom_range(0, 99) < 6);
      cnt = (cnt + 1) % 6;
      v   = ($urandom_range(0, 99) < 88) ? 3'(cnt) : 3'($urandom_range(0, 7));
      applyStimulus(en, clr, v);
    end

    @(negedge clk);
    checkOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
